// File: rtl/tree_sum_accumulator.sv
// Frame accumulator for adder-tree root sums: sums a valid/ready stream of beats
// per frame and hands the total, beat count and sticky overflow flag downstream.
module tree_sum_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             out_ovf_o
);

  typedef enum logic {S_ACC, S_HOLD} state_t;
  state_t state, state_nxt;

  logic [ACC_W-1:0] acc, base, beat, sum;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt, beat_ovf, first, in_fire, out_fire;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // Working registers are zeroed at every frame boundary, so a zero count marks the first beat.
  assign first    = (cnt == '0);
  assign beat     = ACC_W'($signed(in_data_i));
  assign base     = first ? '0 : acc;
  assign sum      = base + beat;
  assign beat_ovf = (base[ACC_W-1] == beat[ACC_W-1]) & (sum[ACC_W-1] != base[ACC_W-1]);
  assign ovf_nxt  = (~first & ovf) | beat_ovf;
  assign cnt_nxt  = first ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:  if (in_fire && in_last_i) state_nxt = S_HOLD;
      S_HOLD: if (out_fire) state_nxt = (in_fire && in_last_i) ? S_HOLD : S_ACC;
      default: state_nxt = S_ACC;
    endcase
    if (clear_i) state_nxt = S_ACC;
  end

  // Ready passes through out_ready_i in HOLD so frames can run back to back.
  always_comb begin
    out_valid_o = (state == S_HOLD);
    in_ready_o  = ~clear_i & ((state == S_ACC) | out_ready_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      out_data_o  <= '0;
      out_count_o <= '0;
      out_ovf_o   <= 1'b0;
    end else if (clear_i) begin
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      out_data_o  <= '0;
      out_count_o <= '0;
      out_ovf_o   <= 1'b0;
    end else if (in_fire) begin
      if (in_last_i) begin
        out_data_o  <= sum;
        out_count_o <= cnt_nxt;
        out_ovf_o   <= ovf_nxt;
        acc         <= '0;
        cnt         <= '0;
        ovf         <= 1'b0;
      end else begin
        acc <= sum;
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
      end
    end
  end

endmodule
